// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher feeding the IF/ID register through a small tagged FIFO.
// Define IFB_FLUSH_CNT_EN to add the flush_cnt_o discarded-work counter.
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_rdata_i,
  output logic                       out_valid_o,
  output logic [31:0]                out_instr_o,
  output logic [31:0]                out_pc_o,
  output logic [31:0]                out_pc_incr_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef IFB_FLUSH_CNT_EN
  ,
  output logic [15:0]                flush_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          push, pop, discard;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  // A single request is in flight at a time; an ack seen outside REQ/DROP is stale and ignored.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    discard    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect_i && (count_q != FULL)) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          if (redirect_i) begin
            discard = 1'b1;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          discard = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
    end
  end

  always_comb begin
    pop      = (count_q != '0) && out_ready_i && !redirect_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop) count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  assign mem_req_o     = (state_q == REQ);
  assign mem_addr_o    = addr_q;
  assign out_valid_o   = (count_q != '0);
  assign out_instr_o   = instr_mem_q[rd_ptr_q];
  assign out_pc_o      = pc_mem_q[rd_ptr_q];
  assign out_pc_incr_o = pc_mem_q[rd_ptr_q] + 32'd4;
  assign count_o       = count_q;

`ifdef IFB_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q;
  logic [16:0] flush_sum;

  // Flushed entries are the pre-redirect occupancy; the sum is clamped rather than wrapped.
  always_comb begin
    flush_sum = {1'b0, flush_cnt_q}
              + (redirect_i ? 17'(count_q) : 17'd0)
              + (discard ? 17'd1 : 17'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) flush_cnt_q <= '0;
    else       flush_cnt_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end

  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: a per-cycle vector table for sequential
// fetch followed by hand-written sequences for full, redirect, wrap and reset corners.
module tb_instr_prefetch_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        out_valid_o;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_pc_incr_o;
  logic        out_ready_i;
  logic [2:0]  count_o;
`ifdef IFB_FLUSH_CNT_EN
  logic [15:0] flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .out_valid_o(out_valid_o), .out_instr_o(out_instr_o),
    .out_pc_o(out_pc_o), .out_pc_incr_o(out_pc_incr_o), .out_ready_i(out_ready_i),
    .count_o(count_o)
`ifdef IFB_FLUSH_CNT_EN
    , .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ack;
    logic [31:0] rdAddr;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expIncr;
    logic [2:0]  expCount;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the inputs for the next rising edge, then settle just after it.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic ready,
                               input logic redir, input logic [31:0] rpc);
    mem_ack_i     = ack;
    mem_rdata_i   = rdata;
    out_ready_i   = ready;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b0;
  endtask

  task automatic idle(input logic ready);
    applyStimulus(1'b0, 32'h0, ready, 1'b0, 32'h0);
  endtask

  task automatic ackWord(input logic [31:0] a, input logic ready);
    applyStimulus(1'b1, memWord(a), ready, 1'b0, 32'h0);
  endtask

  initial begin
    rst_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0; out_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;

    //          ack   addr   rdy  req  maddr  vld  pc     incr   cnt
    vecs[0] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0,  3'd0};
    vecs[1] = '{1'b1, 32'd0,  1'b1, 1'b0, 32'd0,  1'b1, 32'd0,  32'd4,  3'd1};
    vecs[2] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  32'd0,  3'd0};
    vecs[3] = '{1'b1, 32'd4,  1'b1, 1'b0, 32'd0,  1'b1, 32'd4,  32'd8,  3'd1};
    vecs[4] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd8,  1'b0, 32'd0,  32'd0,  3'd0};
    vecs[5] = '{1'b1, 32'd8,  1'b1, 1'b0, 32'd0,  1'b1, 32'd8,  32'd12, 3'd1};
    vecs[6] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd12, 1'b0, 32'd0,  32'd0,  3'd0};
    vecs[7] = '{1'b1, 32'd12, 1'b1, 1'b0, 32'd0,  1'b1, 32'd12, 32'd16, 3'd1};
    vecs[8] = '{1'b0, 32'd0,  1'b1, 1'b1, 32'd16, 1'b0, 32'd0,  32'd0,  3'd0};

    // Reset state
    doReset();
    checkOutput("rst_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("rst_count", {29'd0, count_o}, 32'd0);
`ifdef IFB_FLUSH_CNT_EN
    checkOutput("rst_flush", {16'd0, flush_cnt_o}, 32'd0);
`endif

    // Sequential fetch, ack one cycle after each request, consumer always ready
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].ack, vecs[i].ack ? memWord(vecs[i].rdAddr) : 32'h0,
                    vecs[i].ready, 1'b0, 32'h0);
      checkOutput($sformatf("seq%0d_req", i), {31'd0, mem_req_o}, {31'd0, vecs[i].expReq});
      if (vecs[i].expReq)
        checkOutput($sformatf("seq%0d_addr", i), mem_addr_o, vecs[i].expAddr);
      checkOutput($sformatf("seq%0d_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].expValid});
      if (vecs[i].expValid) begin
        checkOutput($sformatf("seq%0d_pc", i), out_pc_o, vecs[i].expPc);
        checkOutput($sformatf("seq%0d_incr", i), out_pc_incr_o, vecs[i].expIncr);
        checkOutput($sformatf("seq%0d_instr", i), out_instr_o, memWord(vecs[i].expPc));
      end
      checkOutput($sformatf("seq%0d_count", i), {29'd0, count_o}, {29'd0, vecs[i].expCount});
    end

    // Fill to full with the consumer stalled
    doReset();
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      checkOutput($sformatf("fill%0d_req", i), {31'd0, mem_req_o}, 32'd1);
      checkOutput($sformatf("fill%0d_addr", i), mem_addr_o, 32'(4 * i));
      ackWord(32'(4 * i), 1'b0);
      checkOutput($sformatf("fill%0d_count", i), {29'd0, count_o}, 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checkOutput($sformatf("full%0d_req", i), {31'd0, mem_req_o}, 32'd0);
      checkOutput($sformatf("full%0d_count", i), {29'd0, count_o}, 32'd4);
      checkOutput($sformatf("full%0d_pc", i), out_pc_o, 32'd0);
      checkOutput($sformatf("full%0d_instr", i), out_instr_o, memWord(32'd0));
    end
    idle(1'b1);
    checkOutput("full_pop_pc", out_pc_o, 32'd4);
    checkOutput("full_pop_count", {29'd0, count_o}, 32'd3);

    // Redirect with a request outstanding; the ack returns three cycles later
    doReset();
    idle(1'b1);
    checkOutput("drop_req0", mem_addr_o, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
    checkOutput("drop_req_low", {31'd0, mem_req_o}, 32'd0);
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'h0);
    checkOutput("drop_valid", {31'd0, out_valid_o}, 32'd0);
    checkOutput("drop_count", {29'd0, count_o}, 32'd0);
`ifdef IFB_FLUSH_CNT_EN
    checkOutput("drop_flush", {16'd0, flush_cnt_o}, 32'd1);
`endif
    idle(1'b0);
    checkOutput("drop_next_req", {31'd0, mem_req_o}, 32'd1);
    checkOutput("drop_next_addr", mem_addr_o, 32'h0000_0100);
    ackWord(32'h100, 1'b0);
    checkOutput("drop_out_pc", out_pc_o, 32'h0000_0100);
    checkOutput("drop_out_instr", out_instr_o, memWord(32'h100));

    // Redirect coinciding with ack and pop while two entries are queued
    doReset();
    for (int i = 0; i < 2; i++) begin
      idle(1'b0);
      ackWord(32'(4 * i), 1'b0);
    end
    idle(1'b0);
    checkOutput("coinc_pre_count", {29'd0, count_o}, 32'd2);
    checkOutput("coinc_pre_addr", mem_addr_o, 32'd8);
    applyStimulus(1'b1, memWord(32'd8), 1'b1, 1'b1, 32'h0000_0200);
    checkOutput("coinc_count", {29'd0, count_o}, 32'd0);
    checkOutput("coinc_valid", {31'd0, out_valid_o}, 32'd0);
`ifdef IFB_FLUSH_CNT_EN
    checkOutput("coinc_flush", {16'd0, flush_cnt_o}, 32'd3);
`endif
    idle(1'b1);
    checkOutput("coinc_req", {31'd0, mem_req_o}, 32'd1);
    checkOutput("coinc_addr", mem_addr_o, 32'h0000_0200);
    ackWord(32'h200, 1'b0);
    checkOutput("coinc_out_pc", out_pc_o, 32'h0000_0200);

    // Address wrap past the top of memory, with redirect-to-request latency
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap_lat_req", {31'd0, mem_req_o}, 32'd0);
    idle(1'b0);
    checkOutput("wrap_req0", mem_addr_o, 32'hFFFF_FFF8);
    ackWord(32'hFFFF_FFF8, 1'b0);
    idle(1'b0);
    checkOutput("wrap_req1", mem_addr_o, 32'hFFFF_FFFC);
    ackWord(32'hFFFF_FFFC, 1'b0);
    idle(1'b0);
    checkOutput("wrap_req2", mem_addr_o, 32'h0000_0000);
    ackWord(32'h0, 1'b0);
    checkOutput("wrap_pc0", out_pc_o, 32'hFFFF_FFF8);
    checkOutput("wrap_incr0", out_pc_incr_o, 32'hFFFF_FFFC);
    idle(1'b1);
    checkOutput("wrap_pc1", out_pc_o, 32'hFFFF_FFFC);
    checkOutput("wrap_incr1", out_pc_incr_o, 32'h0000_0000);
    idle(1'b1);
    checkOutput("wrap_pc2", out_pc_o, 32'h0000_0000);
    checkOutput("wrap_incr2", out_pc_incr_o, 32'h0000_0004);
    checkOutput("wrap_instr2", out_instr_o, memWord(32'h0));

    // Reset in the middle of a request, followed by the stale ack
    doReset();
    idle(1'b1);
    ackWord(32'd0, 1'b1);
    idle(1'b1);
    checkOutput("mrst_pre_addr", mem_addr_o, 32'd4);
    doReset();
    checkOutput("mrst_valid0", {31'd0, out_valid_o}, 32'd0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    checkOutput("mrst_valid1", {31'd0, out_valid_o}, 32'd0);
    checkOutput("mrst_count", {29'd0, count_o}, 32'd0);
    checkOutput("mrst_req", {31'd0, mem_req_o}, 32'd1);
    checkOutput("mrst_addr", mem_addr_o, 32'h0000_0000);
    idle(1'b0);
    checkOutput("mrst_valid2", {31'd0, out_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
